// File: rtl/operand_entry.sv
// Two-operand 4-bit signed add/subtract entry: one debounced pushbutton
// walks the FSM through operand A, operand B and result display.
module operand_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLOCK_50,
    input  logic       RST,
    input  logic [3:0] SW,
    input  logic       SW_OP,
    input  logic       KEY_N,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [3:0] R,
    output logic       ovf,
    output logic       VALID,
    output logic [1:0] STATE
);

    localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned DATA_W  = 4;

    localparam logic [1:0] S_A   = 2'b00;
    localparam logic [1:0] S_B   = 2'b01;
    localparam logic [1:0] S_RES = 2'b10;

    logic              key_s1_q, key_s2_q;
    logic              stable_q, stable_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
    logic              ovf_q, ovf_d, valid_q, valid_d;

    logic              key_diff_c, cnt_done_c, press_c;
    logic [DATA_W-1:0] sum_c, diff_c;
    logic              add_ovf_c, sub_ovf_c;

    // Synchronizer, debounce counter and FSM state; reset models a released key.
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            key_s1_q <= 1'b1;
            key_s2_q <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= S_A;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            key_s1_q <= KEY_N;
            key_s2_q <= key_s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    // Debounce: the stable level flips on the cycle the count would reach the limit.
    always_comb begin
        key_diff_c = (key_s2_q != stable_q);
        cnt_done_c = key_diff_c && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
        stable_d   = stable_q;
        cnt_d      = '0;
        if (key_diff_c) begin
            if (cnt_done_c) begin
                stable_d = key_s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_c = cnt_done_c && stable_q;
    end

    always_comb begin
        sum_c     = a_q + b_q;
        diff_c    = a_q - b_q;
        add_ovf_c = (a_q[3] == b_q[3]) && (sum_c[3] != a_q[3]);
        sub_ovf_c = (a_q[3] != b_q[3]) && (diff_c[3] != a_q[3]);
    end

    // Next-state and datapath: operands preview live, result captured on the B press.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        case (state_q)
            S_A: begin
                if (press_c) begin
                    state_d = S_B;
                end else begin
                    a_d = SW;
                end
            end
            S_B: begin
                if (press_c) begin
                    state_d = S_RES;
                    r_d     = SW_OP ? diff_c : sum_c;
                    ovf_d   = SW_OP ? sub_ovf_c : add_ovf_c;
                    valid_d = 1'b1;
                end else begin
                    b_d = SW;
                end
            end
            S_RES: begin
                if (press_c) begin
                    state_d = S_A;
                    r_d     = '0;
                    ovf_d   = 1'b0;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_A;
                r_d     = '0;
                ovf_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign A     = a_q;
    assign B     = b_q;
    assign R     = r_q;
    assign ovf   = ovf_q;
    assign VALID = valid_q;
    assign STATE = state_q;

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with a short debounce window.
module tb_operand_entry;

    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic       sw_op;
    logic       key_n;
    logic [3:0] a, b, r;
    logic       ovf, valid;
    logic [1:0] state;

    int n_checks;
    int n_errors;

    operand_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50 (clk),
        .RST      (rst),
        .SW       (sw),
        .SW_OP    (sw_op),
        .KEY_N    (key_n),
        .A        (a),
        .B        (b),
        .R        (r),
        .ovf      (ovf),
        .VALID    (valid),
        .STATE    (state)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        key_n = 1'b0;
        tick(8);
        key_n = 1'b1;
        tick(8);
    endtask

    task automatic check_all(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                             input logic [3:0] er, input logic eo, input logic ev,
                             input logic [1:0] es);
        check({tag, ".A"},     8'(a),     8'(ea));
        check({tag, ".B"},     8'(b),     8'(eb));
        check({tag, ".R"},     8'(r),     8'(er));
        check({tag, ".ovf"},   8'(ovf),   8'(eo));
        check({tag, ".VALID"}, 8'(valid), 8'(ev));
        check({tag, ".STATE"}, 8'(state), 8'(es));
    endtask

    // Full A op B entry from S_A, result check, then press back to S_A.
    task automatic do_op(input string tag, input logic [3:0] va, input logic [3:0] vb,
                         input logic op, input logic [3:0] er, input logic eo);
        sw = va;
        tick(2);
        press();
        sw    = vb;
        sw_op = op;
        tick(2);
        press();
        check_all(tag, va, vb, er, eo, 1'b1, 2'b10);
        press();
        check({tag, ".back"}, 8'(state), 8'h00);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        sw    = 4'h0;
        sw_op = 1'b0;
        key_n = 1'b1;
        tick(2);
        check_all("reset", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
        rst = 1'b0;

        // Live preview of A, then press latency of 2 + 4 cycles.
        sw = 4'h3;
        tick(2);
        check("preview_a", 8'(a), 8'h03);
        key_n = 1'b0;
        tick(5);
        check("latency_early", 8'(state), 8'h00);
        tick(1);
        check("latency_edge", 8'(state), 8'h01);
        key_n = 1'b1;
        tick(8);
        sw = 4'h4;
        tick(2);
        check("hold_a", 8'(a), 8'h03);
        check("preview_b", 8'(b), 8'h04);
        sw_op = 1'b0;
        press();
        check_all("add_3_4", 4'h3, 4'h4, 4'h7, 1'b0, 1'b1, 2'b10);

        // Result state ignores SW/SW_OP; press clears result and resumes A preview.
        sw    = 4'h9;
        sw_op = 1'b1;
        tick(3);
        check_all("res_hold", 4'h3, 4'h4, 4'h7, 1'b0, 1'b1, 2'b10);
        press();
        check("clr.STATE", 8'(state), 8'h00);
        check("clr.R",     8'(r),     8'h00);
        check("clr.ovf",   8'(ovf),   8'h00);
        check("clr.VALID", 8'(valid), 8'h00);
        check("clr.A",     8'(a),     8'h09);

        do_op("add_7_1", 4'h7, 4'h1, 1'b0, 4'h8, 1'b1);
        do_op("add_8_8", 4'h8, 4'h8, 1'b0, 4'h0, 1'b1);
        do_op("sub_8_1", 4'h8, 4'h1, 1'b1, 4'h7, 1'b1);
        do_op("sub_f_f", 4'hF, 4'hF, 1'b1, 4'h0, 1'b0);
        do_op("sub_2_5", 4'h2, 4'h5, 1'b1, 4'hD, 1'b0);

        // Bouncing key: toggling every 2 cycles never settles, then a held low advances once.
        for (int i = 0; i < 10; i++) begin
            key_n = ~key_n;
            tick(2);
        end
        check("bounce_none", 8'(state), 8'h00);
        key_n = 1'b0;
        tick(10);
        check("bounce_one", 8'(state), 8'h01);
        key_n = 1'b1;
        tick(8);
        check("bounce_release", 8'(state), 8'h01);
        key_n = 1'b0;
        tick(3);
        key_n = 1'b1;
        tick(8);
        check("glitch", 8'(state), 8'h01);

        // Asynchronous reset in S_RES with key held low.
        sw    = 4'h2;
        sw_op = 1'b0;
        tick(2);
        press();
        check("pre_rst.STATE", 8'(state), 8'h02);
        key_n = 1'b0;
        tick(2);
        #2 rst = 1'b1;
        #1 check_all("async_rst", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'b00);
        tick(2);
        rst = 1'b0;
        tick(1);
        key_n = 1'b1;
        tick(10);
        check("rst_no_adv", 8'(state), 8'h00);
        check("rst_no_valid", 8'(valid), 8'h00);
        press();
        check("rst_fresh", 8'(state), 8'h01);

        // Key held through reset release: one press after full debounce from release.
        key_n = 1'b0;
        rst   = 1'b1;
        tick(3);
        check("held_rst", 8'(state), 8'h00);
        rst = 1'b0;
        tick(5);
        check("held_early", 8'(state), 8'h00);
        tick(1);
        check("held_edge", 8'(state), 8'h01);
        tick(10);
        check("held_once", 8'(state), 8'h01);
        key_n = 1'b1;
        tick(8);
        check("held_release", 8'(state), 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 The block SHALL have parameter: DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a KEY_N level change (10 ms at 50 MHz; benches use 4).
REQ-002 The block SHALL have port: CLOCK_50  input  1  sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port: RST  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port: SW  input  4  operand value, 4-bit two's complement, asynchronous to clock.
REQ-005 The block SHALL have port: SW_OP  input  1  operation select, 0 = A+B, 1 = A-B.
REQ-006 The block SHALL have port: KEY_N  input  1  advance pushbutton, active-low, bouncy, asynchronous.
REQ-007 The block SHALL have ports: A, B, R  output  4 each  operand A, operand B, result, two's complement, for the display driver.
REQ-008 The block SHALL have port: ovf  output  1  signed overflow of R.
REQ-009 The block SHALL have port: VALID  output  1  R and ovf hold a computed result.
REQ-010 The block SHALL have port: STATE  output  2  current FSM state code for LEDs.

Function
REQ-011 KEY_N SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Debounce: a counter SHALL increment each cycle the synchronized level differs from the stable level, clear to 0 whenever they match, and on reaching DEBOUNCE_CYCLES the stable level SHALL take the synchronized level and the counter SHALL clear.
REQ-013 A press event SHALL be a single-cycle pulse on the stable level's 1->0 transition; holding the key SHALL produce no further events; release SHALL produce none.
REQ-014 Press latency from KEY_N falling (clean) to pulse SHALL be 2 + DEBOUNCE_CYCLES cycles, +/-1.
REQ-015 FSM states: S_A = 2'b00, S_B = 2'b01, S_RES = 2'b10; STATE SHALL equal the state code; code 2'b11 SHALL recover to S_A on the next cycle.
REQ-016 In S_A: A SHALL register SW every cycle (live preview); on press, A SHALL hold its last registered value and FSM SHALL go to S_B.
REQ-017 In S_B: B SHALL register SW every cycle; A SHALL hold; on press, FSM SHALL go to S_RES and R, ovf SHALL register the result of A op B using SW_OP sampled in that same cycle.
REQ-018 Add: R = (A+B) mod 16; ovf = 1 iff A[3]==B[3] and R[3]!=A[3].
REQ-019 Sub: R = (A-B) mod 16; ovf = 1 iff A[3]!=B[3] and R[3]!=A[3].
REQ-020 R, ovf, VALID SHALL update one cycle after the press pulse; VALID SHALL be 1 only in S_RES.
REQ-021 In S_RES: A, B, R, ovf SHALL hold; SW and SW_OP changes SHALL be ignored; on press, FSM SHALL go to S_A, and R, ovf, VALID SHALL clear to 0 on that transition.
REQ-022 Outputs SHALL be registered; no combinational path from SW, SW_OP or KEY_N to any output.

Reset
REQ-023 RST asserted SHALL immediately (no clock) force A=0, B=0, R=0, ovf=0, VALID=0, STATE=S_A, synchronizer flops=1, stable level=1 (released), debounce counter=0.
REQ-024 A key held low through RST deassertion SHALL generate one press event only after full debounce from deassertion, never from pre-reset history.
REQ-025 RST asserted mid-debounce or in any state SHALL discard the partial count and any pending result.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 RST pulse mid-operation in S_RES with KEY_N low -> all outputs 0, STATE=00 in same cycle, no advance until release and fresh press.
REQ-027 SW=0011, press, SW=0100, SW_OP=0, press -> A=0011, B=0100, R=0111, ovf=0, VALID=1, STATE=10.
REQ-028 A=0111, B=0001, add -> R=1000, ovf=1; A=1000, B=1000, add -> R=0000, ovf=1.
REQ-029 A=1000, B=0001, sub -> R=0111, ovf=1; A=1111, B=1111, sub -> R=0000, ovf=0.
REQ-030 KEY_N toggling every 2 cycles for 20 cycles then held low -> exactly one state advance; a 3-cycle low glitch -> no advance.
REQ-031 In S_RES, change SW and SW_OP, then press -> A, B, R unchanged until press; after press STATE=00, R=0, ovf=0, VALID=0, A tracks SW.
